// File: rtl/prog_loader.sv
// Boot/program loader: receives a framed byte image from a host, holds the CPU,
// and writes the image into RAM through the shared bus using MAR/RAM strobes.
module prog_loader #(
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        bus_en,
    output logic [15:0] bus_out,
    output logic        mar_loadh,
    output logic        mar_loadl,
    output logic        ram_load,
    output logic        cpu_hold,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int unsigned IW = $clog2(TIMEOUT + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_HDR   = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_ADDR  = 3'd3;
    localparam logic [2:0] S_WRITE = 3'd4;
    localparam logic [2:0] S_CHK   = 3'd5;
    localparam logic [2:0] S_FIN   = 3'd6;

    logic [2:0]    state_q, state_d;
    logic [1:0]    hdr_cnt_q, hdr_cnt_d;
    logic [15:0]   addr_q, addr_d;
    logic [15:0]   len_q, len_d;
    logic [7:0]    byte_q, byte_d;
    logic [7:0]    sum_q, sum_d;
    logic [IW-1:0] idle_q, idle_d;
    logic          err_q, err_d;

    logic          xfer;
    logic          waiting;
    logic [7:0]    chk_sum;

    assign waiting  = (state_q == S_HDR) || (state_q == S_DATA) || (state_q == S_CHK);
    assign in_ready = waiting;
    assign xfer     = in_valid && in_ready;
    assign chk_sum  = sum_q + in_data;

    always_comb begin
        state_d   = state_q;
        hdr_cnt_d = hdr_cnt_q;
        addr_d    = addr_q;
        len_d     = len_q;
        byte_d    = byte_q;
        sum_d     = sum_q;
        err_d     = err_q;
        idle_d    = '0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_HDR;
                    err_d     = 1'b0;
                    hdr_cnt_d = '0;
                    addr_d    = '0;
                    len_d     = '0;
                    sum_d     = '0;
                end
            end
            S_HDR: begin
                if (xfer) begin
                    hdr_cnt_d = hdr_cnt_q + 2'd1;
                    case (hdr_cnt_q)
                        2'd0: addr_d[15:8] = in_data;
                        2'd1: addr_d[7:0]  = in_data;
                        2'd2: len_d[15:8]  = in_data;
                        default: begin
                            len_d[7:0] = in_data;
                            state_d    = ({len_q[15:8], in_data} == 16'h0000) ? S_CHK : S_DATA;
                        end
                    endcase
                end
            end
            S_DATA: begin
                if (xfer) begin
                    byte_d  = in_data;
                    sum_d   = chk_sum;
                    state_d = S_ADDR;
                end
            end
            S_ADDR: state_d = S_WRITE;
            S_WRITE: begin
                addr_d  = addr_q + 16'd1;
                len_d   = len_q - 16'd1;
                state_d = (len_q == 16'd1) ? S_CHK : S_DATA;
            end
            S_CHK: begin
                if (xfer) begin
                    if (chk_sum != 8'h00) err_d = 1'b1;
                    state_d = S_FIN;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Idle watchdog only runs while waiting on the host; a stall aborts the session.
        if (waiting && !xfer) begin
            if (idle_q == IW'(TIMEOUT - 1)) begin
                state_d = S_FIN;
                err_d   = 1'b1;
            end else begin
                idle_d = idle_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            hdr_cnt_q <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            byte_q    <= '0;
            sum_q     <= '0;
            idle_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            hdr_cnt_q <= hdr_cnt_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            byte_q    <= byte_d;
            sum_q     <= sum_d;
            idle_q    <= idle_d;
            err_q     <= err_d;
        end
    end

    // Strobes are masked by rst so a reset landing on WRITE never commits a byte.
    assign mar_loadh = (state_q == S_ADDR) && !rst;
    assign mar_loadl = mar_loadh;
    assign ram_load  = (state_q == S_WRITE) && !rst;
    assign bus_en    = mar_loadh || ram_load;
    assign bus_out   = mar_loadh ? addr_q :
                       ram_load  ? {8'h00, byte_q} : 16'h0000;

    assign busy     = (state_q != S_IDLE);
    assign cpu_hold = busy;
    assign done     = (state_q == S_FIN) && !err_q;
    assign err      = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: a stream model predicts the bus strobes and
// session outcome; a negedge monitor checks them as the DUT produces them.
module tb_prog_loader;

    localparam int unsigned TIMEOUT = 1023;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready, bus_en, mar_loadh, mar_loadl, ram_load;
    logic        cpu_hold, busy, done, err;
    logic [15:0] bus_out;

    prog_loader #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .bus_en(bus_en), .bus_out(bus_out), .mar_loadh(mar_loadh),
        .mar_loadl(mar_loadl), .ram_load(ram_load), .cpu_hold(cpu_hold), .busy(busy),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // kind: 0 = MAR load (addr), 1 = RAM write (data), 2 = done pulse, 3 = session end (err)
    typedef struct {
        int          kind;
        logic [15:0] val;
    } exp_t;

    exp_t        sb[$];
    logic [7:0]  dat[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    bit          monitor_en = 1'b1;
    logic        prev_busy = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic pop_check(input int kind, input logic [15:0] act, input string nm);
        exp_t e;
        n_chk++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL %s: unexpected event kind %0d value %0h, nothing expected", nm, kind, act);
        end else begin
            e = sb.pop_front();
            if (e.kind != kind || e.val !== act) begin
                n_fail++;
                $display("FAIL %s: got kind %0d value %0h expected kind %0d value %0h (cycle %0d)",
                         nm, kind, act, e.kind, e.val, cyc);
            end
        end
    endtask

    always @(negedge clk) begin
        if (monitor_en && !rst) begin
            if (bus_en || mar_loadh || mar_loadl || ram_load)
                check("strobe_invariant",
                      {28'd0, bus_en, mar_loadh & ram_load, mar_loadh ^ mar_loadl, 1'b0},
                      {28'd0, mar_loadh | ram_load, 1'b0, 1'b0, 1'b0});
            else if (bus_out !== 16'h0000)
                check("bus_idle_zero", {16'd0, bus_out}, 32'd0);
            if (mar_loadh) pop_check(0, bus_out, "mar_addr");
            if (ram_load)  pop_check(1, bus_out, "ram_data");
            if (done)      pop_check(2, {15'd0, err}, "done_pulse");
            if (prev_busy && !busy) begin
                pop_check(3, {15'd0, err}, "end_err");
                check("end_cpu_hold", {31'd0, cpu_hold}, 32'd0);
            end
        end
        prev_busy = busy;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_after_start", {30'd0, busy, cpu_hold}, 32'd3);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, output int acc_cyc);
        bit ok;
        in_valid = 1'b0;
        repeat (gap) tick();
        in_valid = 1'b1;
        in_data  = b;
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        acc_cyc = cyc;
        if (!ok) begin
            n_chk++;
            n_fail++;
            $display("FAIL accept_timeout: byte %0h not accepted, in_ready=%0b expected 1", b, in_ready);
        end
        tick();
    endtask

    task automatic wait_idle(input int bound);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        check("session_ends", {31'd0, ok}, 32'd1);
        tick();
    endtask

    // chk_in < 0 means send the correct checksum for the payload in dat.
    task automatic run_session(input logic [15:0] a, input int chk_in, input int gapmax, input bit tight);
        int          sum;
        logic [7:0]  cv;
        logic [15:0] len;
        int          c, prev_c;
        exp_t        e;
        sum = 0;
        foreach (dat[i]) sum += dat[i];
        cv  = (chk_in < 0) ? 8'((256 - (sum % 256)) % 256) : 8'(chk_in);
        len = 16'(dat.size());
        foreach (dat[i]) begin
            e.kind = 0; e.val = 16'((int'(a) + i) % 65536); sb.push_back(e);
            e.kind = 1; e.val = {8'h00, dat[i]};           sb.push_back(e);
        end
        if ((sum + cv) % 256 == 0) begin
            e.kind = 2; e.val = 16'h0000; sb.push_back(e);
        end
        e.kind = 3; e.val = ((sum + cv) % 256 == 0) ? 16'h0000 : 16'h0001; sb.push_back(e);

        do_start();
        send_byte(a[15:8], $urandom_range(0, gapmax), c);
        send_byte(a[7:0], $urandom_range(0, gapmax), c);
        send_byte(len[15:8], $urandom_range(0, gapmax), c);
        send_byte(len[7:0], $urandom_range(0, gapmax), c);
        prev_c = 0;
        foreach (dat[i]) begin
            send_byte(dat[i], tight ? 0 : $urandom_range(0, gapmax), c);
            if (tight && i > 0) check("byte_spacing", c - prev_c, 3);
            prev_c = c;
        end
        send_byte(cv, tight ? 0 : $urandom_range(0, gapmax), c);
        wait_idle(50);
    endtask

    initial begin
        int c, n;
        logic [15:0] ra;
        repeat (3) tick();
        check("reset_outputs",
              {in_ready, bus_en, bus_out, mar_loadh, mar_loadl, ram_load, cpu_hold, busy, done, err}, 32'd0);
        rst = 1'b0;
        in_valid = 1'b1;
        in_data = 8'h5A;
        repeat (2) tick();
        check("idle_outputs",
              {in_ready, bus_en, bus_out, mar_loadh, mar_loadl, ram_load, cpu_hold, busy, done, err}, 32'd0);
        in_valid = 1'b0;

        dat = '{8'h3E, 8'h07};
        run_session(16'h0010, 8'hBB, 2, 1'b0);
        dat = {};
        run_session(16'h1234, 8'h00, 2, 1'b0);
        dat = '{8'hAA};
        run_session(16'h0000, 8'h00, 2, 1'b0);
        check("err_sticky", {31'd0, err}, 32'd1);
        dat = '{8'($urandom), 8'($urandom)};
        run_session(16'hFFFF, -1, 2, 1'b0);
        check("err_cleared", {31'd0, err}, 32'd0);

        // Back-pressure: valid held high while start is pulsed mid-session.
        dat = {};
        for (int i = 0; i < 6; i++) dat.push_back(8'($urandom));
        fork
            run_session(16'h2000, -1, 0, 1'b1);
            begin
                repeat (9) tick();
                start = 1'b1;
                tick();
                start = 1'b0;
            end
        join

        for (int s = 0; s < 8; s++) begin
            dat = {};
            n = $urandom_range(0, 6);
            for (int i = 0; i < n; i++) dat.push_back(8'($urandom));
            ra = 16'($urandom);
            if (s == 3) ra = 16'hFFFD;
            run_session(ra, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : -1, 3, 1'b0);
        end

        // Host stalls after the header: watchdog must abort with err.
        begin
            exp_t e;
            e.kind = 3; e.val = 16'h0001; sb.push_back(e);
            do_start();
            send_byte(8'h30, 0, c);
            send_byte(8'h00, 0, c);
            send_byte(8'h00, 0, c);
            send_byte(8'h03, 0, c);
            in_valid = 1'b0;
            n = 0;
            while (busy && n < int'(TIMEOUT) + 10) begin
                @(negedge clk);
                n++;
            end
            check("timeout_window", {31'd0, (n >= int'(TIMEOUT) && n <= int'(TIMEOUT) + 3)}, 32'd1);
            check("timeout_state", {29'd0, busy, cpu_hold, err}, 32'd1);
            tick();
        end

        // Reset landing while the loader sits in WRITE.
        monitor_en = 1'b0;
        do_start();
        send_byte(8'h40, 0, c);
        send_byte(8'h00, 0, c);
        send_byte(8'h00, 0, c);
        send_byte(8'h02, 0, c);
        send_byte(8'h11, 0, c);
        in_valid = 1'b0;
        n = 0;
        while (!mar_loadh && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("reached_addr", {31'd0, mar_loadh}, 32'd1);
        tick();
        rst = 1'b1;
        @(negedge clk);
        check("rst_cycle_no_write", {30'd0, ram_load, bus_en}, 32'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("after_rst_outputs",
              {in_ready, bus_en, bus_out, mar_loadh, mar_loadl, ram_load, cpu_hold, busy, done, err}, 32'd0);
        tick();
        monitor_en = 1'b1;

        dat = '{8'h01, 8'h02, 8'h03};
        run_session(16'h0100, -1, 1, 1'b0);

        check("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
